sprite_mem_loader: RTL
======================

// Module: sprite_mem_loader
// PURPOSE
//  Write side of the static sprite RAMs. Takes a byte stream (UART/host bridge) with valid/ready.
//  Unpacks one 16x16, 2-bit-per-pixel sprite pattern per packet.
//  Issues one pixel write per cycle to the RAM selected by wr_sel (wr_addr = {x,y}, wr_data, wr_en).
//  The sprite RAM reader then fetches these patterns at runtime instead of relying only on .mif contents.
// PARAMETERS
//  NUM_SPRITES  2    sprite RAMs present; a header selecting index >= NUM_SPRITES is rejected
//  TIMEOUT      4096 max idle cycles between bytes inside a packet; 0 = no timeout
// PORTS
//  clock     in   1  single system clock, all logic on rising edge
//  reset     in   1  synchronous, active-high
//  in_data   in   8  stream byte
//  in_valid  in   1  in_data valid
//  in_ready  out  1  byte accepted on a cycle where in_valid && in_ready
//  wr_sel    out  6  target sprite index (held for whole packet)
//  wr_addr   out  8  pixel address {x[3:0], y[3:0]}
//  wr_data   out  2  pixel value
//  wr_en     out  1  write strobe, one pixel per cycle
//  busy      out  1  high from header accept until packet end/abort
//  done      out  1  1-cycle pulse: packet complete
//  err       out  1  1-cycle pulse: bad header, timeout (or checksum fail, see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=HDR; in_ready=1; wr_en=0; wr_sel=0; wr_addr=0; wr_data=0; busy=0; done=0; err=0; counters 0.
//  Reset mid-packet aborts immediately, with no done/err pulse. Already-written pixels stay in RAM.
//  Packet format: header byte {2'b01, idx[5:0]}, then 64 data bytes.
//   Each data byte carries 4 pixels; bits[1:0] are written first, bits[7:6] last.
//  Pixel counter pc[7:0] runs 0..255 and wr_addr = pc, so y varies fastest, then x.
//  States:
//   HDR:   in_ready=1. On accept:
//          - bits[7:6]!=2'b01 or idx>=NUM_SPRITES -> err pulse next cycle, stay HDR.
//          - else wr_sel<=idx, pc<=0, busy<=1, go BYTE.
//   BYTE:  in_ready=1. On accept, latch byte, go WR with sub-pixel k=0.
//   WR:    in_ready=0. Write pixel k for k=0..3 (4 cycles):
//          wr_en=1, wr_data=byte[2k+1:2k], wr_addr=pc; pc increments after each write.
//          After k=3: if pc wrapped to 0 (256 pixels written) go FIN, else go BYTE.
//   FIN:   done=1 for one cycle, busy<=0, go HDR (in_ready=1 again next cycle).
//  Latency: byte accepted at cycle N -> wr_en high cycles N+1..N+4. Peak rate: 1 byte per 5 cycles.
//  Last data byte accepted at cycle N -> done high at cycle N+5.
//  Registered outputs; wr_addr/wr_data/wr_sel are valid whenever wr_en=1, don't-care otherwise.
//  Timeout (TIMEOUT>0): gap counter clears on each accept and counts only in BYTE.
//   Reaching TIMEOUT -> err pulse, busy<=0, go HDR. No partial-sprite cleanup.
//  in_valid low in BYTE simply stalls; in WR in_valid is ignored (not consumed).
//  Bytes arriving in HDR/BYTE/WR/FIN are never dropped while in_ready=0; the source must hold them.
//  done and err are never asserted in the same cycle.
// CONFIGURATION
//  SPRITE_LOADER_CHECKSUM_EN defined:
//   - Packet gains a trailing 66th byte = XOR of the 64 data bytes.
//   - FIN is preceded by CHK state (in_ready=1) which accepts it.
//   - Match -> done pulse; mismatch -> err pulse and no done. Pixels stay written.
//   - Timeout also applies in CHK.
//  Not defined: 65-byte packets, no CHK state, done always at packet end.
// TESTING
//  1) Header 0x40, 64 bytes 0xE4 -> 256 writes wr_sel=0, wr_data 0,1,2,3 repeating, wr_addr 0x00..0xFF, one done, no err.
//  2) Header 0x41, byte0=0x1B -> first four writes addr 0x00..0x03 data 3,2,1,0; wr_sel=1; in_ready low exactly 4 cycles per byte.
//  3) Header 0x42 (idx 2 >= NUM_SPRITES) and header 0x80 -> err pulse each, no wr_en, busy stays 0.
//  4) Header 0x40, 10 bytes, then in_valid low for TIMEOUT cycles -> err pulse, busy 0, next 0x41 header accepted normally.
//  5) reset asserted during WR of byte 30 -> next cycle wr_en=0, in_ready=1, busy=0, no done/err pulse.
//  6) CHECKSUM_EN: 64 x 0xFF + chk 0x00 -> done. Same data + chk 0x01 -> err, no done. Random in_valid gaps -> identical write sequence.

Source files
------------

// File: rtl/sprite_mem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sprite_mem_loader: unpacks 16x16 2bpp sprite packets from a byte     |
// | stream into per-pixel RAM writes. Option: SPRITE_LOADER_CHECKSUM_EN  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sprite_mem_loader #(
  parameter int NUM_SPRITES = 2,
  parameter int TIMEOUT     = 4096
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [5:0] wr_sel,
  output logic [7:0] wr_addr,
  output logic [1:0] wr_data,
  output logic       wr_en,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_BYTE = 3'd1,
    S_WR   = 3'd2,
    S_CHK  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam int                 c_gap_w     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_gap_w-1:0] c_gap_last  = c_gap_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit                 c_to_en     = (TIMEOUT > 0);
  localparam logic [6:0]         c_num_spr   = 7'(NUM_SPRITES);

  state_t               state_q, state_d;
  logic [7:0]           pc_q, pc_d;
  logic [1:0]           k_q, k_d;
  logic [7:0]           sh_q, sh_d;
  logic [c_gap_w-1:0]   gap_q, gap_d;
  logic [5:0]           wr_sel_q, wr_sel_d;
  logic                 wr_en_q, wr_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 in_ready_q, in_ready_d;
`ifdef SPRITE_LOADER_CHECKSUM_EN
  logic [7:0]           xor_q, xor_d;
`endif

  logic accept;
  logic idle_timeout;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_HDR;
      pc_q       <= '0;
      k_q        <= '0;
      sh_q       <= '0;
      gap_q      <= '0;
      wr_sel_q   <= '0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b1;
`ifdef SPRITE_LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      k_q        <= k_d;
      sh_q       <= sh_d;
      gap_q      <= gap_d;
      wr_sel_q   <= wr_sel_d;
      wr_en_q    <= wr_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
`ifdef SPRITE_LOADER_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    k_d          = k_q;
    sh_d         = sh_q;
    gap_d        = gap_q;
    wr_sel_d     = wr_sel_q;
    wr_en_d      = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
    xor_d        = xor_q;
`endif
    accept       = in_valid && in_ready_q;
    idle_timeout = c_to_en && !accept && (gap_q == c_gap_last);

    case (state_q)
      S_HDR: begin
        if (accept) begin
          if ((in_data[7:6] != 2'b01) || ({1'b0, in_data[5:0]} >= c_num_spr)) begin
            err_d = 1'b1;
          end else begin
            wr_sel_d = in_data[5:0];
            pc_d     = '0;
            gap_d    = '0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
            xor_d    = '0;
`endif
            state_d  = S_BYTE;
          end
        end
      end
      S_BYTE: begin
        if (accept) begin
          // The shift register feeds wr_data directly so the pixel output stays a flop.
          sh_d    = in_data;
          k_d     = '0;
          gap_d   = '0;
          wr_en_d = 1'b1;
`ifdef SPRITE_LOADER_CHECKSUM_EN
          xor_d   = xor_q ^ in_data;
`endif
          state_d = S_WR;
        end else if (idle_timeout) begin
          err_d   = 1'b1;
          state_d = S_HDR;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_WR: begin
        pc_d = pc_q + 8'd1;
        sh_d = {2'b00, sh_q[7:2]};
        k_d  = k_q + 2'd1;
        if (k_q != 2'd3) begin
          wr_en_d = 1'b1;
        end else if (pc_q == 8'hFF) begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          done_d  = 1'b1;
          state_d = S_FIN;
`endif
        end else begin
          state_d = S_BYTE;
        end
      end
`ifdef SPRITE_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          gap_d = '0;
          if (in_data == xor_q) begin
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            err_d   = 1'b1;
            state_d = S_HDR;
          end
        end else if (idle_timeout) begin
          err_d   = 1'b1;
          state_d = S_HDR;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
`endif
      S_FIN: begin
        state_d = S_HDR;
      end
      default: begin
        state_d = S_HDR;
      end
    endcase

    busy_d     = (state_d != S_HDR);
    in_ready_d = (state_d == S_HDR) || (state_d == S_BYTE) || (state_d == S_CHK);
  end

  assign in_ready = in_ready_q;
  assign wr_sel   = wr_sel_q;
  assign wr_addr  = pc_q;
  assign wr_data  = sh_q[1:0];
  assign wr_en    = wr_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
`default_nettype wire
